// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NREQ requesters.
// Optional illegal-opcode flagging on rsp_err is enabled by defining ALU_SHARE_OPCHK_EN.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_ctrl,
    input  logic [31:0]          alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err
);

    logic           can_accept;
    logic           gv;
    logic           op_bad;
    logic [IDW-1:0] g;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic [3:0]     sel_op;

    assign can_accept = !rsp_valid || rsp_ready;

    // Rotating priority: lowest valid index at or above ptr, else lowest below it.
    always_comb begin
        gv     = 1'b0;
        g      = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) < ptr)) begin
                gv     = 1'b1;
                g      = IDW'(i);
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_op[i*4 +: 4];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= ptr)) begin
                gv     = 1'b1;
                g      = IDW'(i);
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
                sel_op = req_op[i*4 +: 4];
            end
        end
    end

    // Only the winner sees ready, and only when the slot can take a result.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = can_accept && gv && (g == IDW'(i));
        end
    end

    // Pointer moves just past the winner, wrapping at NREQ.
    always_comb begin
        if (int'(g) == NREQ - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = g + IDW'(1);
        end
    end

    assign alu_a    = sel_a;
    assign alu_b    = sel_b;
    assign alu_ctrl = sel_op;

`ifdef ALU_SHARE_OPCHK_EN
    assign op_bad = (sel_op == 4'b0110) || (sel_op >= 4'b1010);
`else
    assign op_bad = 1'b0;
`endif

    // Response slot: load on accept, empty on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            ptr       <= '0;
        end else if (gv && can_accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_res;
            rsp_id    <= g;
            rsp_err   <= op_bad;
            ptr       <= ptr_nxt;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU model.
// Expected responses are pushed by the driver and popped by a negedge monitor.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ALU_SHARE_OPCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(2), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return {31'd0, $signed(a) < $signed(b)};
            4'b0111: return a << b[4:0];
            4'b1000: return a >> b[4:0];
            4'b1001: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_res = alu_f(alu_a, alu_b, alu_ctrl);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] d,
                        input logic e);
        exp_t x;
        x.id   = id;
        x.data = d;
        x.err  = e;
        q.push_back(x);
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = v;
        req_op[i*4 +: 4]  = op;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handed over is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id=%0d data=%h want none",
                         rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        next();
        rst_n = 1'b1;

        // 1: single request, add
        set_req(0, 1'b1, 4'b0000, 32'd5, 32'd7);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b01);
        push(2'd0, 32'd12, 1'b0);
        next();
        req_valid = '0;
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        next();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;

        // 2: alternating grants from ptr=0
        set_req(0, 1'b1, 4'b0001, 32'd3, 32'd10);
        set_req(1, 1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_ready", 32'(req_ready), (k % 2 == 1) ? 32'b10 : 32'b01);
            if (k % 2 == 1) push(2'd1, 32'd1, 1'b0);
            else push(2'd0, 32'hFFFF_FFF9, 1'b0);
            next();
        end
        req_valid = '0;
        @(negedge clk);
        next();

        // 3: stall with full slot, then drain and accept together
        set_req(0, 1'b1, 4'b0000, 32'd1, 32'd2);
        @(negedge clk);
        chk("t3_fill_ready", 32'(req_ready), 32'b01);
        push(2'd0, 32'd3, 1'b0);
        next();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'b1001, 32'h8000_0000, 32'd4);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_ready", 32'(req_ready), 32'b00);
            chk("t3_stall_valid", 32'(rsp_valid), 32'd1);
            chk("t3_stall_data", rsp_data, 32'd3);
            chk("t3_stall_id", 32'(rsp_id), 32'd0);
            chk("t3_alu_a", alu_a, 32'h8000_0000);
            next();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain_ready", 32'(req_ready), 32'b10);
        push(2'd1, 32'hF800_0000, 1'b0);
        next();
        req_valid = '0;
        @(negedge clk);
        next();

        // 4: reset drops a pending response and restores ptr
        set_req(0, 1'b1, 4'b0000, 32'd5, 32'd7);
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 32'b01);
        next();
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 4'b0000, 32'd100, 32'd1);
        @(negedge clk);
        chk("t4_full", 32'(rsp_valid), 32'd1);
        chk("t4_full_data", rsp_data, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t4_rst_data", rsp_data, 32'd0);
        next();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_first_grant", 32'(req_ready), 32'b01);
        push(2'd0, 32'd12, 1'b0);
        next();

        // 5: illegal opcode
        req_valid = '0;
        set_req(0, 1'b1, 4'b1010, 32'd1, 32'd1);
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 32'b01);
        push(2'd0, 32'd0, ERR_EXP);
        next();

        // 6: idle cycles leave ALU inputs at zero and ptr unchanged
        req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_alu_a", alu_a, 32'd0);
            chk("t6_alu_b", alu_b, 32'd0);
            chk("t6_alu_ctrl", 32'(alu_ctrl), 32'd0);
            chk("t6_ready", 32'(req_ready), 32'b00);
            next();
        end
        set_req(0, 1'b1, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        set_req(1, 1'b1, 4'b0111, 32'd1, 32'd35);
        @(negedge clk);
        chk("t6_grant_r1", 32'(req_ready), 32'b10);
        push(2'd1, 32'd8, 1'b0);
        next();
        @(negedge clk);
        chk("t6_grant_r0", 32'(req_ready), 32'b01);
        push(2'd0, 32'hFF00_FF00, 1'b0);
        next();
        req_valid = '0;

        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            next();
        end
        chk("drain_left", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU instance between NREQ requesters, for example the EX stage and a multi-cycle mul/div or address-gen unit.
- Arbitrates round-robin over valid/ready request channels.
- Drives the ALU operands and control from the winner.
- Captures the ALU result into a single registered response slot with valid/ready backpressure.
- Sits between the requesters and the ALU, which is instantiated outside this block.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
IDW, 2, width of rsp_id (must satisfy 2**IDW >= NREQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
req_b  in  NREQ*32  operand B, same packing
req_op  in  NREQ*4  ALU control code, requester i at bits [4i+3:4i]
alu_a  out  32  to ALU scra
alu_b  out  32  to ALU scrb
alu_ctrl  out  4  to ALU alucontrol
alu_res  in  32  from ALU aluresult
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer takes the response
rsp_id  out  IDW  index of the requester that owns rsp_data
rsp_data  out  32  registered ALU result
rsp_err  out  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Response slot: one register, EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready. This is a pipelined drain: a new result may load in the same cycle the old one leaves.
- Grant:
  - g = first i with req_valid[i]=1, searched from ptr upward, wrapping modulo NREQ.
  - gv = |req_valid.
  - req_ready[i] = can_accept & gv & (i==g). Combinational from req_valid, rsp_valid and rsp_ready.
  - A requester must hold valid and its payload stable until it sees ready.
- ALU drive:
  - When gv=1, alu_a/alu_b/alu_ctrl = the granted requester's fields.
  - When gv=0, they are 0/0/4'b0000.
  - This holds regardless of can_accept; only the capture is gated.
- Accept (gv & can_accept): on the next edge rsp_valid<=1, rsp_data<=alu_res, rsp_id<=g, rsp_err<=illegal(op), ptr<=(g+1) mod NREQ.
- Drain without accept (rsp_valid & rsp_ready & !gv): rsp_valid<=0. rsp_data, rsp_id and rsp_err hold their values.
- Stall (rsp_valid & !rsp_ready): req_ready=0 everywhere, all rsp_* stable, ptr unchanged.
- Latency: a request accepted in cycle N is visible on rsp_* in cycle N+1. Throughput is 1 per cycle while rsp_ready=1.
- Fairness: with k requesters continuously valid, each is granted once in every k accepts. No requester waits more than NREQ-1 accepts.
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, ptr=0.
  - Asserting reset mid-operation drops any pending response; no partial state survives.
- Arithmetic: this block performs none. It passes 32-bit operands unmodified. The ALU treats its operands as signed and uses only the low 5 bits of B for shifts.
- ALU code map, for illegal-op detection: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0111 sll, 1000 srl, 1001 sra. Codes 0110 and 1010-1111 are illegal; the ALU returns 0 for them.

Optional Feature:
- Macro: ALU_SHARE_OPCHK_EN.
- Defined: illegal(op)=1 for codes 0110 and 1010-1111. The request is still accepted and answered with rsp_data=0 (the ALU output) and rsp_err=1. Legal codes give rsp_err=0.
- Not defined: illegal() is constant 0, so rsp_err stays 0 permanently. The port remains present in both builds.

Test Plan:
1. Reset, then requester 0 alone sends op=0000, a=5, b=7 -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12.
2. Both requesters valid for 4 cycles with rsp_ready=1: r0 op=0001 a=3 b=10; r1 op=0101 a=0xFFFFFFFF b=1 -> grants alternate 0,1,0,1; rsp_data alternates 0xFFFFFFF9 and 1.
3. rsp_ready=0 for 3 cycles with the slot full -> req_ready=0, rsp_* unchanged. Then raise rsp_ready with r1 valid (op=1001, a=0x80000000, b=4) -> same-cycle drain and accept; next rsp_data=0xF8000000.
4. Apply reset while rsp_valid=1 and a request is pending -> rsp_valid=0, rsp_data=0 immediately. After release the first grant goes to the lowest valid index (ptr=0).
5. Requester 0 sends op=1010, a=1, b=1 -> with ALU_SHARE_OPCHK_EN: rsp_data=0, rsp_err=1. Without the macro: rsp_data=0, rsp_err=0.
6. Idle cycle (no req_valid) -> alu_a=alu_b=0, alu_ctrl=0000, req_ready=0, ptr unchanged.
